// File: rtl/seg7_capture_decoder.sv
// Seven-segment bus capture: sync, debounce, decode, valid/ready output.
// Optional SEG7_CAP_BLANK_EN accepts the all-off pattern as a blank digit.
module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_value,
    output logic       out_blank,
    output logic       invalid,
    output logic       overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(STABLE_CYCLES);

    typedef enum logic {SETTLE, LOCKED} state_t;

    state_t      state;
    logic [6:0]  s1, s2;
    logic [6:0]  last_locked;
    logic        last_empty;
    logic [CW-1:0] cnt, cnt_nxt;
    logic        changed, lock, fresh, legal, load;
    logic [3:0]  code;

    // s1 holds the value s2 takes next edge, so a mismatch marks a change
    assign changed = (s1 != s2);
    assign cnt_nxt = changed ? '0 :
                     (cnt == RUN_MAX) ? cnt : cnt + 1'b1;
    assign lock  = (state == SETTLE) && !changed && (cnt_nxt == RUN_MAX);
    assign fresh = last_empty || (s2 != last_locked);
    assign load  = lock && fresh && legal && (!out_valid || out_ready);

    always_comb begin
        legal = 1'b1;
        code  = 4'h0;
        unique case (s2)
            7'h40: code = 4'h0;
            7'h79: code = 4'h1;
            7'h24: code = 4'h2;
            7'h30: code = 4'h3;
            7'h19: code = 4'h4;
            7'h12: code = 4'h5;
            7'h02: code = 4'h6;
            7'h78: code = 4'h7;
            7'h00: code = 4'h8;
            7'h10: code = 4'h9;
            7'h08: code = 4'hA;
            7'h03: code = 4'hB;
            7'h46: code = 4'hC;
            7'h21: code = 4'hD;
            7'h06: code = 4'hE;
            7'h0E: code = 4'hF;
`ifdef SEG7_CAP_BLANK_EN
            7'h7F: code = 4'h0;
`endif
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= 7'h7F;
            s2          <= 7'h7F;
            cnt         <= '0;
            state       <= SETTLE;
            last_locked <= 7'h7F;
            last_empty  <= 1'b1;
            out_valid   <= 1'b0;
            out_value   <= 4'h0;
            invalid     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            s1      <= seg_in;
            s2      <= s1;
            cnt     <= cnt_nxt;
            invalid <= 1'b0;
            overrun <= 1'b0;
            if (changed)
                state <= SETTLE;
            else if (lock)
                state <= LOCKED;
            // A lock onto the glyph already seen is a glitch recovery
            if (lock && fresh) begin
                last_locked <= s2;
                last_empty  <= 1'b0;
                if (!legal)
                    invalid <= 1'b1;
                else if (!load)
                    overrun <= 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_value <= code;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SEG7_CAP_BLANK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_blank <= 1'b0;
        else if (load)
            out_blank <= (s2 == 7'h7F);
    end
`else
    assign out_blank = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: spec-level model plus directed checks.
// Honours SEG7_CAP_BLANK_EN in both model and literal expectations.
module tb_seg7_capture_decoder;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_value;
    logic       out_blank;
    logic       invalid;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    seg7_capture_decoder #(.STABLE_CYCLES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg_in   (seg_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_value(out_value),
        .out_blank(out_blank),
        .invalid  (invalid),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] glyph [16];
    initial begin
        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
        glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
    end

    // Model: pattern seen by the capture logic lags the pins by two edges.
    logic [6:0] m_s1, m_s2, m_last;
    int         m_age;
    bit         m_empty, m_valid, m_blank, m_inv, m_ovr;
    logic [3:0] m_value;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = 7'h7F; m_s2 = 7'h7F; m_last = 7'h7F; m_age = 0;
                m_empty = 1; m_valid = 0; m_value = 0; m_blank = 0;
                m_inv = 0; m_ovr = 0;
            end else begin
                bit xfer, chg, ok, blk, loaded;
                logic [3:0] cd;
                logic [6:0] p;
                xfer = m_valid && out_ready;
                chg  = (m_s1 != m_s2);
                m_s2 = m_s1;
                m_s1 = seg_in;
                if (chg) m_age = 0;
                else if (m_age <= N) m_age++;
                m_inv = 0; m_ovr = 0; loaded = 0;
                if (!chg && m_age == N) begin
                    p = m_s2;
                    if (m_empty || p != m_last) begin
                        m_empty = 0;
                        m_last  = p;
                        ok = 0; blk = 0; cd = 0;
                        for (int i = 0; i < 16; i++)
                            if (glyph[i] == p) begin ok = 1; cd = 4'(i); end
`ifdef SEG7_CAP_BLANK_EN
                        if (p == 7'h7F) begin ok = 1; blk = 1; cd = 0; end
`endif
                        if (!ok) m_inv = 1;
                        else if (!m_valid || xfer) begin
                            loaded = 1; m_valid = 1; m_value = cd; m_blank = blk;
                        end else m_ovr = 1;
                    end
                end
                if (!loaded && xfer) m_valid = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            tests++;
            if (!rst_n) begin
                if ({out_valid, out_value, out_blank, invalid, overrun} != 8'h0) begin
                    fails++;
                    $display("FAIL reset_outs got v=%0b val=%h b=%0b inv=%0b ovr=%0b want all 0",
                             out_valid, out_value, out_blank, invalid, overrun);
                end
            end else if (out_valid !== m_valid || out_value !== m_value ||
                         out_blank !== m_blank || invalid !== m_inv || overrun !== m_ovr) begin
                fails++;
                $display("FAIL cycle_model t=%0t got v=%0b val=%h b=%0b inv=%0b ovr=%0b want v=%0b val=%h b=%0b inv=%0b ovr=%0b",
                         $time, out_valid, out_value, out_blank, invalid, overrun,
                         m_valid, m_value, m_blank, m_inv, m_ovr);
            end
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    int nv, ni, no, nb;

    task automatic clr();
        nv = 0; ni = 0; no = 0; nb = 0;
    endtask

    task automatic window(input int n);
        repeat (n) begin
            @(negedge clk);
            nv += int'(out_valid);
            ni += int'(invalid);
            no += int'(overrun);
            nb += int'(out_valid && out_blank);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; seg_in = 7'h7F; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        lit("reset_state", int'({out_valid, out_value, out_blank, invalid, overrun}), 0);

        // 24 -> code 2, valid first visible after edge N+2
        rst_n = 1'b1; seg_in = 7'h24;
        repeat (N + 1) @(negedge clk);
        lit("t1_not_yet", int'(out_valid), 0);
        @(negedge clk);
        lit("t1_valid", int'(out_valid), 1);
        lit("t1_value", int'(out_value), 2);
        lit("t1_model_value", int'(m_value), 2);
        clr(); window(12);
        lit("t1_no_repeat", nv, 0);
        lit("t1_no_invalid", ni, 0);

        // 0E held with ready low, then single transfer
        seg_in = 7'h0E; out_ready = 1'b0;
        clr(); window(20);
        lit("t2_valid", int'(out_valid), 1);
        lit("t2_value", int'(out_value), 15);
        lit("t2_held_cycles", nv, 20 - N - 1);
        out_ready = 1'b1;
        @(negedge clk);
        lit("t2_xfer_clear", int'(out_valid), 0);
        clr(); window(5);
        lit("t2_stays_clear", nv, 0);

        // glitch filtering
        seg_in = 7'h30;
        clr(); window(10);
        lit("t3_emit_3", nv, 1);
        lit("t3_value", int'(out_value), 3);
        seg_in = 7'h7E;
        repeat (2) @(negedge clk);
        seg_in = 7'h30;
        clr(); window(12);
        lit("t3_glitch_no_emit", nv, 0);
        lit("t3_glitch_no_inv", ni, 0);
        seg_in = 7'h7E;
        clr(); window(6);
        seg_in = 7'h30;
        window(10);
        lit("t3_long_invalid", ni, 1);
        lit("t3_reemit", nv, 1);

        // overrun
        out_ready = 1'b0; seg_in = 7'h79;
        clr(); window(10);
        seg_in = 7'h19;
        window(10);
        lit("t4_value_kept", int'(out_value), 1);
        lit("t4_valid", int'(out_valid), 1);
        lit("t4_overrun", no, 1);
        out_ready = 1'b1;
        @(negedge clk);

        // all-off pattern
        seg_in = 7'h7F;
        clr(); window(10);
`ifdef SEG7_CAP_BLANK_EN
        lit("t5_blank_emit", nv, 1);
        lit("t5_blank_flag", nb, 1);
        lit("t5_blank_value", int'(out_value), 0);
        lit("t5_no_invalid", ni, 0);
`else
        lit("t5_no_emit", nv, 0);
        lit("t5_invalid", ni, 1);
        lit("t5_blank_tied", int'(out_blank), 0);
`endif

        // async reset while holding output
        out_ready = 1'b0; seg_in = 7'h24;
        clr(); window(10);
        lit("t6_valid_before", int'(out_valid), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 lit("t6_async_clear", int'({out_valid, out_value, out_blank, invalid, overrun}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 1) @(negedge clk);
        lit("t6_not_yet", int'(out_valid), 0);
        @(negedge clk);
        lit("t6_reemit", int'(out_valid), 1);
        lit("t6_value", int'(out_value), 2);
        window(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
